// File: rtl/uart_rx.sv
// uart_rx -- asynchronous serial receiver.
//
// Samples an idle-high serial line and reassembles frames made of one start bit (0),
// DATA_BITS data bits LSB first, an optional parity bit and one stop bit (1).
// Each bit is sampled at its centre, which is found by timing half a bit from the
// detected falling edge of the start bit.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous, active-high reset
//   i_rx          serial line, asynchronous to i_clk, idle high
//   O_Data        last correctly framed byte; changes only when O_Valid pulses
//   O_Valid       one-cycle strobe: O_Data holds a newly received byte
//   O_Busy        high while a frame is in progress
//   O_Frame_Err   one-cycle strobe: stop bit sampled as 0 (O_Data left unchanged)
//   O_Parity_Err  one-cycle strobe, coincident with O_Valid: parity mismatch
module uart_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] O_Data,
  output logic                 O_Valid,
  output logic                 O_Busy,
  output logic                 O_Frame_Err,
  output logic                 O_Parity_Err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  // Parity check: 1 when data plus received parity bit disagree with the chosen sense.
  function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p ^ (PARITY_ODD != 0);
  endfunction

  logic rx_p0, rx_p1;
  logic vld_p0, vld_p1;
  logic rx_s;
  logic armed;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d, perr_out_d;

  // stage p0/p1: two-flop synchronizer for the asynchronous line. The vld flags mark
  // when the chain holds real line samples rather than the reset fill value, so that
  // arming never trusts the reset-forced 1s.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_p0  <= 1'b1;
      rx_p1  <= 1'b1;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      rx_p0  <= i_rx;
      rx_p1  <= rx_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
    end
  end

  assign rx_s = rx_p1;

  // Start detection is only allowed once the line has been seen idle (high), so a
  // reset in the middle of a frame or a line stuck low cannot fake a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      armed <= 1'b0;
    end else if (vld_p1 && rx_s) begin
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    data_d     = O_Data;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_out_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          // A line back high at mid start bit was a glitch, not a frame.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[bit_q] = rx_s;
          cnt_d          = '0;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          perr_d  = parity_err(shift_q, rx_s);
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a start bit that follows immediately be caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d     = shift_q;
            valid_d    = 1'b1;
            perr_out_d = (PARITY_EN != 0) ? perr_q : 1'b0;
            state_d    = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // stage p2: frame control and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      O_Data       <= '0;
      O_Valid      <= 1'b0;
      O_Frame_Err  <= 1'b0;
      O_Parity_Err <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      O_Data       <= data_d;
      O_Valid      <= valid_d;
      O_Frame_Err  <= ferr_d;
      O_Parity_Err <= perr_out_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
    perr_q  <= perr_d;
  end

  assign O_Busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx.
//
// Two receivers share clock and reset: dut0 without parity, dut1 with even parity.
// Frames are driven bit by bit on each line; for every frame the expected strobe
// (byte or framing error, parity flag, and the cycle it must appear in) is pushed
// into a per-receiver queue. Independent monitors pop and compare whenever a
// receiver raises O_Valid or O_Frame_Err.
module tb_uart_rx;

  localparam int C = 8;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1;
  logic [7:0] data0, data1;
  logic       valid0, busy0, ferr0, perr0;
  logic       valid1, busy1, ferr1, perr1;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(D), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx0), .O_Data(data0), .O_Valid(valid0),
    .O_Busy(busy0), .O_Frame_Err(ferr0), .O_Parity_Err(perr0)
  );

  uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(D), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx1), .O_Data(data1), .O_Valid(valid1),
    .O_Busy(busy1), .O_Frame_Err(ferr1), .O_Parity_Err(perr1)
  );

  typedef struct {
    bit ferr;
    int data;
    bit perr;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   vcyc0[$];
  int   last0 = 0;
  int   last1 = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  int   busy_rises = 0;
  int   busy_rise_cyc = 0;
  int   busy_fall_cyc = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor for dut0
  always @(negedge clk) begin
    if (!rst && (valid0 || ferr0)) begin
      check("dut0 valid/ferr overlap", int'(valid0 && ferr0), 0);
      if (valid0) vcyc0.push_back(cyc);
      if (q0.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut0 unexpected strobe: valid=%0d ferr=%0d data=0x%0h at cycle %0d, expected none",
                 valid0, ferr0, data0, cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0 frame_err", int'(ferr0), int'(e.ferr));
        check("dut0 valid", int'(valid0), int'(!e.ferr));
        check("dut0 data", int'(data0), e.data);
        check("dut0 parity_err", int'(perr0), int'(e.perr));
        check("dut0 strobe cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for dut1
  always @(negedge clk) begin
    if (!rst && (valid1 || ferr1)) begin
      check("dut1 valid/ferr overlap", int'(valid1 && ferr1), 0);
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut1 unexpected strobe: valid=%0d ferr=%0d data=0x%0h at cycle %0d, expected none",
                 valid1, ferr1, data1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1 frame_err", int'(ferr1), int'(e.ferr));
        check("dut1 valid", int'(valid1), int'(!e.ferr));
        check("dut1 data", int'(data1), e.data);
        check("dut1 parity_err", int'(perr1), int'(e.perr));
        check("dut1 strobe cycle", cyc, e.cyc);
      end
    end
  end

  // Busy edge recorder for dut0
  always @(negedge clk) begin
    if (busy0 === 1'b1 && busy_prev == 1'b0) begin
      busy_rise_cyc = cyc;
      busy_rises++;
    end
    if (busy0 === 1'b0 && busy_prev == 1'b1) busy_fall_cyc = cyc;
    busy_prev = (busy0 === 1'b1);
  end

  // Hold a line level for n clock cycles; called at 1 time unit after a rising edge.
  task automatic drive(input int sel, input logic b, input int n);
    if (sel == 0) rx0 = b;
    else rx1 = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one frame. stop_len==0: normal stop bit; otherwise stop held low that long.
  task automatic send(input int sel, input int data, input int pbit, input int stop_len,
                      output int n_start);
    exp_t       e;
    logic [7:0] d8;
    int         p;
    p       = (sel == 1) ? 1 : 0;
    d8      = data[7:0];
    n_start = cyc;
    // Line falls now; it is registered on the next edge (E0 = n_start+1).
    e.cyc   = n_start + 1 + 2 + C / 2 + (D + 1 + p) * C;
    if (stop_len == 0) begin
      e.ferr = 1'b0;
      e.data = int'(d8);
      e.perr = (p == 1) ? ((($countones(d8) + pbit) % 2) != 0) : 1'b0;
      if (sel == 0) last0 = int'(d8);
      else last1 = int'(d8);
    end else begin
      e.ferr = 1'b1;
      e.data = (sel == 0) ? last0 : last1;
      e.perr = 1'b0;
    end
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
    drive(sel, 1'b0, C);
    for (int i = 0; i < D; i++) drive(sel, d8[i], C);
    if (p == 1) drive(sel, pbit[0], C);
    if (stop_len == 0) begin
      drive(sel, 1'b1, C);
    end else begin
      drive(sel, 1'b0, stop_len);
      drive(sel, 1'b1, C);
    end
  endtask

  task automatic glitch(input int len);
    drive(0, 1'b0, len);
    drive(0, 1'b1, 2 * C);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ns, ns2, dummy, rises, mode;
    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset data0", int'(data0), 0);
    check("reset valid0", int'(valid0), 0);
    check("reset busy0", int'(busy0), 0);
    check("reset ferr0", int'(ferr0), 0);
    check("reset perr0", int'(perr0), 0);
    check("reset busy1", int'(busy1), 0);
    rst = 1'b0;
    drive(0, 1'b1, 6);

    // Single frame 0x64 with busy timing
    send(0, 'h64, 0, 0, ns);
    check("t1 busy rise cycle", busy_rise_cyc, ns + 3);
    check("t1 busy fall cycle", busy_fall_cyc, ns + 1 + 2 + C / 2 + (D + 1) * C);
    drive(0, 1'b1, 2 * C);

    // Back-to-back frames
    send(0, 'h64, 0, 0, ns);
    send(0, 'h5A, 0, 0, ns2);
    drive(0, 1'b1, C);
    check("t2 valid spacing", vcyc0[vcyc0.size() - 1] - vcyc0[vcyc0.size() - 2], (D + 2) * C);
    check("t2 last data", int'(data0), 'h5A);

    // Short low glitch, then a good frame
    rises = busy_rises;
    glitch(2);
    check("t3 glitch busy pulses", busy_rises - rises, 1);
    check("t3 busy idle after glitch", int'(busy0), 0);
    send(0, 'hA5, 0, 0, dummy);
    drive(0, 1'b1, C);

    // Framing error: stop bit held low for 16 cycles
    send(0, 'h3C, 0, 16, ns);
    check("t4 busy fall after break", busy_fall_cyc, ns + (1 + D) * C + 16 + 3);
    check("t4 data kept", int'(data0), 'hA5);
    drive(0, 1'b1, C);

    // Reset in the middle of data bit 3 while the line is low
    drive(0, 1'b0, C + 3 * C + C / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last0 = 0;
    last1 = 0;
    check("t6 data0 after reset", int'(data0), 0);
    check("t6 busy0 after reset", int'(busy0), 0);
    check("t6 valid0 after reset", int'(valid0), 0);
    check("t6 ferr0 after reset", int'(ferr0), 0);
    drive(0, 1'b0, C / 2 - 1 + 4 * C);
    drive(0, 1'b1, 2 * C);
    send(0, 'h81, 0, 0, dummy);
    drive(0, 1'b1, C);

    // Parity receiver: even parity, good then bad parity bit
    drive(1, 1'b1, C);
    send(1, 'h07, 1, 0, dummy);
    send(1, 'h07, 0, 0, dummy);
    drive(1, 1'b1, C);

    // Randomized traffic on dut0
    for (int k = 0; k < 40; k++) begin
      drive(0, 1'b1, $urandom_range(0, 10));
      mode = $urandom_range(0, 7);
      if (mode == 0) begin
        glitch($urandom_range(1, 2));
      end else if (mode == 1) begin
        send(0, $urandom_range(0, 255), 0, $urandom_range(C, 2 * C), dummy);
        drive(0, 1'b1, C);
      end else begin
        send(0, $urandom_range(0, 255), 0, 0, dummy);
      end
    end

    // Randomized traffic on dut1 with random parity bits
    for (int k = 0; k < 15; k++) begin
      drive(1, 1'b1, $urandom_range(0, 6));
      send(1, $urandom_range(0, 255), $urandom_range(0, 1), 0, dummy);
    end

    drive(0, 1'b1, 3 * C);
    check("dut0 pending expectations", q0.size(), 0);
    check("dut1 pending expectations", q1.size(), 0);
    check("dut0 final data", int'(data0), last0);
    check("dut1 final data", int'(data1), last1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
